// File: rtl/rr_req_arbiter.sv
// Round-robin request arbiter with a registered one-hot grant.
// A grant is held until the resource accepts it or the requester withdraws.
// The next winner is the first requester at or after a rotating priority
// pointer, wrapping past the top index back to 0.

// Running OR from bit 0 upward: o_ext[i] = |i_vec[i:0].
// The pointer mask is built from this, and so is the lowest-set-bit pick.
module extend_first1 #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_vec,
    output logic [W-1:0] o_ext
);
    logic w_acc;

    // Prefix-OR chain, evaluated within one block to keep it a single net
    always_comb begin
        w_acc = 1'b0;
        o_ext = '0;
        for (int i = 0; i < W; i++) begin
            w_acc    = w_acc | i_vec[i];
            o_ext[i] = w_acc;
        end
    end
endmodule

// Isolates the lowest set bit of a vector and reports whether any bit is set.
module rr_first_pick #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_vec,
    output logic [W-1:0] o_pick,
    output logic         o_any
);
    logic [W-1:0] w_ext;

    extend_first1 #(.W(W)) u_ext (
        .i_vec (i_vec),
        .o_ext (w_ext)
    );

    // A bit survives only if no lower bit is set
    assign o_pick = i_vec & ~{w_ext[W-2:0], 1'b0};
    assign o_any  = w_ext[W-1];
endmodule

// Wrap-around first-one search starting at the one-hot pointer position.
module rr_sel #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_req,
    input  logic [W-1:0] i_ptr_oh,
    output logic [W-1:0] o_pick,
    output logic         o_any
);
    logic [W-1:0] w_mask;
    logic [W-1:0] w_hi;
    logic [W-1:0] w_hi_pick;
    logic         w_hi_any;
    logic [W-1:0] w_lo_pick;
    logic         w_lo_any;

    // Thermometer mask with bits [W-1:ptr] set
    extend_first1 #(.W(W)) u_mask (
        .i_vec (i_ptr_oh),
        .o_ext (w_mask)
    );

    assign w_hi = i_req & w_mask;

    rr_first_pick #(.W(W)) u_hi (
        .i_vec  (w_hi),
        .o_pick (w_hi_pick),
        .o_any  (w_hi_any)
    );

    // Fallback search over all requests covers the wrap past index 0
    rr_first_pick #(.W(W)) u_lo (
        .i_vec  (i_req),
        .o_pick (w_lo_pick),
        .o_any  (w_lo_any)
    );

    assign o_pick = w_hi_any ? w_hi_pick : w_lo_pick;
    assign o_any  = w_lo_any;
endmodule

module rr_req_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_aL,
    input  logic [N_REQ-1:0] req,
    input  logic             res_ready,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [IDX_W-1:0] ptr
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_ptr;

    logic [N_REQ-1:0] w_grant_next;
    logic [IDX_W-1:0] w_idx_next;
    logic [IDX_W-1:0] w_ptr_next;

    logic [N_REQ-1:0] w_ptr_oh;
    logic [N_REQ-1:0] w_rot_oh;
    logic [N_REQ-1:0] w_idle_pick;
    logic             w_idle_any;
    logic [N_REQ-1:0] w_acc_pick;
    logic             w_acc_any;
    logic             w_held;
    logic             w_accept;
    logic             w_withdraw;
    logic [IDX_W-1:0] w_ptr_inc;

    // Decode the binary pointer to one-hot for the mask chain
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ptr_dec
            assign w_ptr_oh[gi] = (r_ptr == IDX_W'(gi));
        end
    endgenerate

    // Position after the current grant, as one-hot: rotate left by one
    assign w_rot_oh = {r_grant[N_REQ-2:0], r_grant[N_REQ-1]};

    // Same position in binary, wrapping explicitly at the top index
    assign w_ptr_inc = (r_grant_idx == IDX_W'(N_REQ - 1)) ? '0
                                                          : r_grant_idx + IDX_W'(1);

    // Is the granted requester still asking?
    assign w_held     = |(req & r_grant);
    assign w_accept   = (r_state == BUSY) && w_held && res_ready;
    assign w_withdraw = (r_state == BUSY) && !w_held;

    // Fresh arbitration from IDLE at the stored pointer
    rr_sel #(.W(N_REQ)) u_sel_idle (
        .i_req    (req),
        .i_ptr_oh (w_ptr_oh),
        .o_pick   (w_idle_pick),
        .o_any    (w_idle_any)
    );

    // Back-to-back re-selection on accept; the accepted bit is excluded and
    // search starts just past it, so newly raised bits are eligible at once
    rr_sel #(.W(N_REQ)) u_sel_next (
        .i_req    (req & ~r_grant),
        .i_ptr_oh (w_rot_oh),
        .o_pick   (w_acc_pick),
        .o_any    (w_acc_any)
    );

    // State and data registers; reset drops any held grant immediately
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_grant_idx <= w_idx_next;
            r_ptr       <= w_ptr_next;
        end
    end

    // Next-state decision: IDLE waits for any request, BUSY leaves on
    // withdraw or on an accept that finds no other requester
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: w_state_next = w_idle_any ? BUSY : IDLE;
            BUSY: begin
                if (w_withdraw) begin
                    w_state_next = IDLE;
                end else if (w_accept) begin
                    w_state_next = w_acc_any ? BUSY : IDLE;
                end else begin
                    w_state_next = BUSY;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Next grant and pointer; stalls hold everything, withdraw keeps the pointer
    always_comb begin
        w_grant_next = r_grant;
        w_ptr_next   = r_ptr;
        case (r_state)
            IDLE: w_grant_next = w_idle_pick;
            BUSY: begin
                if (w_withdraw) begin
                    w_grant_next = '0;
                end else if (w_accept) begin
                    w_grant_next = w_acc_pick;
                    w_ptr_next   = w_ptr_inc;
                end
            end
            default: w_grant_next = '0;
        endcase
    end

    // Binary index of the next grant; zero when nothing is granted
    always_comb begin
        w_idx_next = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_next[i]) begin
                w_idx_next = w_idx_next | IDX_W'(i);
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_idx   = r_grant_idx;
    assign ptr         = r_ptr;
endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: a directed vector table covering
// the rotation, wrap, back-pressure and withdraw cases, hand-written reset
// sequences, then randomized traffic against a rotating-search model.
module tb_rr_req_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst_aL;
    logic [N-1:0]  req;
    logic          res_ready;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] ptr;

    int n_checks;
    int n_err;
    bit mon_on;

    rr_req_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst_aL      (rst_aL),
        .req         (req),
        .res_ready   (res_ready),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .ptr         (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  req;
        logic          rdy;
        logic [N-1:0]  exp_grant;
        logic [IW-1:0] exp_ptr;
    } vec_t;

    vec_t vecs[19];

    // Reference model: index of held grant (-1 = none) and priority pointer
    int m_idx;
    int m_ptr;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    // First requester found walking upward from p, wrapping modulo N
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            int i;
            i = (p + j) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rdy);
        if (m_idx < 0) begin
            m_idx = pick(r, m_ptr);
        end else if (!r[m_idx]) begin
            m_idx = -1;
        end else if (rdy) begin
            logic [N-1:0] rest;
            rest = r;
            rest[m_idx] = 1'b0;
            m_ptr = (m_idx + 1) % N;
            m_idx = pick(rest, m_ptr);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (m_idx >= 0) eg[m_idx] = 1'b1;
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_valid"}, 32'(grant_valid), 32'(m_idx >= 0));
        chk({tag, "_idx"},   32'(grant_idx), 32'((m_idx >= 0) ? m_idx : 0));
        chk({tag, "_ptr"},   32'(ptr), 32'(m_ptr));
    endtask

    // Invariant on every cycle: grant is one-hot or zero, valid is its OR
    always @(negedge clk) begin
        if (mon_on && rst_aL) begin
            n_checks++;
            if (!$onehot0(grant) || (grant_valid !== (|grant))) begin
                n_err++;
                $display("FAIL onehot grant=%b valid=%b", grant, grant_valid);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic         rd;

        n_checks = 0;
        n_err    = 0;
        mon_on   = 1'b0;

        // Directed table, starting from reset: {req, res_ready, grant, ptr}
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
        vecs[6]  = '{4'b0110, 1'b1, 4'b0100, 2'd2};
        vecs[7]  = '{4'b0100, 1'b1, 4'b0000, 2'd3};
        vecs[8]  = '{4'b0011, 1'b0, 4'b0001, 2'd3};
        vecs[9]  = '{4'b0001, 1'b1, 4'b0000, 2'd1};
        vecs[10] = '{4'b0100, 1'b0, 4'b0100, 2'd1};
        vecs[11] = '{4'b0100, 1'b0, 4'b0100, 2'd1};
        vecs[12] = '{4'b0101, 1'b0, 4'b0100, 2'd1};
        vecs[13] = '{4'b0101, 1'b0, 4'b0100, 2'd1};
        vecs[14] = '{4'b0101, 1'b1, 4'b0001, 2'd3};
        vecs[15] = '{4'b0011, 1'b1, 4'b0010, 2'd1};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 2'd1};
        vecs[17] = '{4'b1010, 1'b0, 4'b0010, 2'd1};
        vecs[18] = '{4'b1010, 1'b1, 4'b1000, 2'd2};

        // Reset held with all requests up: nothing may be granted
        rst_aL    = 1'b0;
        req       = 4'b1111;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_idx",   32'(grant_idx), 32'd0);
        chk("rst_ptr",   32'(ptr), 32'd0);
        rst_aL = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < 19; i++) begin
            req       = vecs[i].req;
            res_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            chk($sformatf("v%0d_ptr", i),   32'(ptr), 32'(vecs[i].exp_ptr));
            chk($sformatf("v%0d_valid", i), 32'(grant_valid), 32'(|vecs[i].exp_grant));
            chk($sformatf("v%0d_idx", i),   32'(grant_idx), 32'(oh2idx(vecs[i].exp_grant)));
            $display("vec %0d req=%b rdy=%b grant=%b ptr=%0d", i, vecs[i].req, vecs[i].rdy, grant, ptr);
        end

        // Asynchronous reset between edges while index 3 is granted
        chk("pre_arst_grant", 32'(grant), 32'b1000);
        #2;
        rst_aL = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_valid", 32'(grant_valid), 32'd0);
        chk("arst_ptr",   32'(ptr), 32'd0);
        $display("async reset mid-grant grant=%b ptr=%0d", grant, ptr);
        #2;
        rst_aL = 1'b1;
        m_idx  = -1;
        m_ptr  = 0;

        // Randomized traffic; granted requesters usually keep asking
        for (int c = 0; c < 600; c++) begin
            r = N'($urandom_range(0, (1 << N) - 1));
            if (m_idx >= 0 && $urandom_range(0, 3) != 0) r[m_idx] = 1'b1;
            rd = 1'($urandom_range(0, 1));
            req       = r;
            res_ready = rd;
            @(posedge clk);
            model_step(r, rd);
            #1;
            chk_model($sformatf("rnd%0d", c));
            $display("rnd %0d req=%b rdy=%b grant=%b ptr=%0d", c, r, rd, grant, ptr);
        end

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rr_req_arbiter.md
# rr_req_arbiter

Round-robin arbiter that shares one single-ported resource among `N_REQ` requesters, for example a CDB write slot or a dcache port. It holds a registered one-hot grant until the resource accepts it. The next grant goes to the first requester at or after a rotating priority pointer, wrapping around past index 0. Selection uses a wrap-around first-one search (thermometer mask plus lowest-set-bit pick); `extend_first1` supplies the mask/priority chain.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2; need not be a power of two.
- `IDX_W`, default `$clog2(N_REQ)`: width of the index and pointer fields.

Ports:
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst_aL`  in  1  — asynchronous, active-low reset.
- `req`  in  N_REQ  — one level-sensitive request bit per requester.
- `res_ready`  in  1  — resource accepts the current grant this cycle.
- `grant`  out  N_REQ  — registered one-hot grant, or zero when nothing is granted.
- `grant_valid`  out  1  — equals OR of `grant`.
- `grant_idx`  out  IDX_W  — binary index of the granted requester; 0 when `grant_valid` is 0.
- `ptr`  out  IDX_W  — current priority pointer; exported for debug and verification.

## Operation
- State: `IDLE` (no grant held) and `BUSY` (a grant is held). The grant register and `ptr` are the only other state.
- Select function `sel(req, ptr)`:
  - `hi = req & mask`, where `mask` has bits `[N_REQ-1:ptr]` set.
  - If `hi != 0`, pick the lowest set bit of `hi`; otherwise pick the lowest set bit of `req`.
  - If `req == 0`, there is no pick.
- `IDLE`:
  - If `sel` has a pick, load `grant` with the pick and go to `BUSY`.
  - Otherwise stay in `IDLE` with `grant = 0`.
- `BUSY`, with granted index k:
  - **Accept** (`res_ready` = 1 and `req[k]` = 1):
    - Set `ptr` ← (k+1) mod N_REQ.
    - Evaluate `sel(req & ~grant, (k+1) mod N_REQ)`.
    - If it has a pick, load the new grant and stay in `BUSY` (back-to-back, no bubble). Otherwise clear `grant` and go to `IDLE`.
  - **Withdraw** (`req[k]` = 0, regardless of `res_ready`): clear `grant`, go to `IDLE`, leave `ptr` unchanged. No transfer is counted.
  - **Stall** (`res_ready` = 0 and `req[k]` = 1): hold `grant`, `grant_idx` and `ptr` unchanged. New or changed requests on other bits have no effect.
- Requesters must hold `req` high until the cycle their grant is accepted.
- `res_ready` is ignored when `grant_valid` = 0.
- Pointer arithmetic wraps explicitly at `N_REQ-1` → 0 and never indexes past `N_REQ-1`.
- Invariant: `grant` is one-hot or zero in every cycle. The bench checks this every cycle.

## Timing
- Reset (`rst_aL` = 0, asynchronous, takes effect without a clock edge):
  - `grant` = 0, `grant_valid` = 0, `grant_idx` = 0, `ptr` = 0, state `IDLE`.
  - Reset mid-`BUSY` drops the grant immediately.
  - First arbitration is on the first rising edge after `rst_aL` goes high.
- Latency:
  - `req` rising in cycle t while `IDLE` → `grant` visible in cycle t+1.
  - Accept in cycle t → next grant, or zero, in cycle t+1.
  - Sustained throughput is one grant per cycle.
- Accept and withdraw are sampled at the rising edge. Outputs are purely registered, with no combinational path from `req`/`res_ready` to `grant`.
- Simultaneous accept and new request on another bit: the new bit is eligible in the same edge's re-selection.

## Test plan
- **Reset:** hold `rst_aL` = 0 with `req` = 4'b1111 → `grant` = 0, `grant_valid` = 0, `ptr` = 0. Release → `grant` = 4'b0001 one cycle later.
- **Full rotation:** `req` = 4'b1111 and `res_ready` = 1 continuously → `grant` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; `ptr` sequence 1, 2, 3, 0.
- **Wrap-around:** after accepting index 2 (`ptr` = 3), drive `req` = 4'b0011 → `grant` = 4'b0001, `grant_idx` = 0.
- **Back-pressure:**
  - Stimulus: `req` = 4'b0100, `res_ready` = 0 for 3 cycles, with `req[0]` raised in the 2nd stall cycle.
  - Response while stalled: `grant` stays 4'b0100, `grant_idx` = 2, `ptr` unchanged.
  - Then `res_ready` = 1 → next cycle `grant` = 4'b0001 and `ptr` = 3.
- **Withdraw:**
  - Stimulus: while index 1 is granted, drop `req[1]` with `res_ready` = 0.
  - Response: next cycle `grant` = 0 and `ptr` unchanged.
  - Then `req` = 4'b1010 → `grant` = 4'b0010 one cycle later.
- **Async reset mid-grant:** pulse `rst_aL` low between clock edges while `grant` = 4'b1000 → `grant` = 0 and `ptr` = 0 immediately, before the next edge.
